ras_recovery: RTL
=================

RAS_RECOVERY -- requirements
Module: ras_recovery

Interface
REQ-001 SHALL have parameter STACK_SIZE, default 8, giving the depth of the return-address stack whose state is checkpointed.
REQ-002 SHALL have parameter CKPT_DEPTH, default 8 (power of two), giving the number of checkpoint entries.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 alloc_valid  input  2  per fetch slot, a predicted branch needs a checkpoint; slot 0 is older.
REQ-006 alloc_ptr  input  2 x clog2(STACK_SIZE)  speculative RAS pointer per slot, before that slot's push/pop.
REQ-007 alloc_tos  input  2 x 32  RAS entry at alloc_ptr-1 per slot.
REQ-008 alloc_ready  output  1  high when at least 2 checkpoint entries are free.
REQ-009 alloc_tag  output  2 x clog2(CKPT_DEPTH)  tag assigned to each valid slot, combinational.
REQ-010 resolve_valid  input  1  one branch resolves this cycle.
REQ-011 resolve_tag  input  clog2(CKPT_DEPTH)  tag of the resolving branch.
REQ-012 resolve_mispredict  input  1  the resolving branch was mispredicted.
REQ-013 restore_valid  output  1  one-cycle pulse; the RAS must reload its pointer and top entry.
REQ-014 restore_ptr  output  clog2(STACK_SIZE)  pointer value to reload.
REQ-015 restore_tos  output  32  top-of-stack value to write at restore_ptr-1.

Function
REQ-016 SHALL hold checkpoints in a circular buffer with head and tail pointers of clog2(CKPT_DEPTH)+1 bits, the extra bit being the wrap bit; full and empty SHALL be told apart by the wrap bit.
REQ-017 Allocation SHALL occur only when alloc_ready is high; slot 0 SHALL take tag tail[low bits] and slot 1 SHALL take the next tag; only valid slots consume entries.
REQ-018 If only slot 1 is valid, it SHALL receive tag tail[low bits].
REQ-019 Each entry SHALL store ptr, tos, a valid bit and a resolved bit; a new entry SHALL be valid and unresolved.
REQ-020 Correct resolve (resolve_valid and not resolve_mispredict) of a valid entry SHALL set its resolved bit.
REQ-021 The head SHALL advance over up to 2 consecutive valid, resolved entries per cycle, clearing their valid bits.
REQ-022 Mispredict resolve of a valid entry T SHALL register restore_ptr and restore_tos from entry T and pulse restore_valid in the next cycle, a latency of 1.
REQ-023 On that mispredict, tail SHALL become T+1 with the correct wrap bit, and all entries younger than T SHALL be invalidated.
REQ-024 Entry T itself SHALL be marked resolved on that mispredict.
REQ-025 Mispredict and alloc_valid in the same cycle: the mispredict SHALL win, allocation SHALL be dropped and the tail SHALL not advance for it.
REQ-026 Resolve of an invalid or already-squashed tag SHALL be ignored, with no restore and no state change.
REQ-027 Head freeing and allocation in the same cycle SHALL both take effect; alloc_ready SHALL be computed from pre-update occupancy.
REQ-028 Pointer and tag arithmetic SHALL wrap modulo 2^width with no saturation.
REQ-029 restore_valid SHALL be low in every cycle not immediately following an accepted mispredict.

Reset
REQ-030 Asserting reset SHALL immediately clear head, tail and all valid and resolved bits, set restore_valid=0, restore_ptr=0 and restore_tos=0, and drive alloc_ready=1.
REQ-031 Reset asserted mid-operation SHALL abandon a pending restore, and no restore_valid pulse SHALL follow reset release.

Structure
REQ-032 STACK_SIZE and CKPT_DEPTH defaults, the ckpt_entry_t struct (ptr, tos, valid, resolved) and the tag typedef SHALL live in the shared package ras_pkg, also used by the RAS.
REQ-033 The block SHALL be a single module with no sub-module, with the entry array inline.

Verification
REQ-034 After reset, allocate slot0 ptr=3 tos=0x1004, then mispredict tag 0 -> the next cycle shows restore_valid=1, restore_ptr=3, restore_tos=0x1004 for exactly one cycle.
REQ-035 Allocate 8 single entries without resolves -> alloc_ready=0 after the 7th; the 8th is held until a head entry resolves correctly, after which alloc_ready=1.
REQ-036 Allocate tags 0..3, mispredict tag 1 -> restore uses entry 1, the next allocation receives tag 2, and a later resolve of tag 3 causes no restore.
REQ-037 Mispredict tag 2 while alloc_valid=2'b11 -> no new tags consumed and tail = 3.
REQ-038 Fill to wrap (tags 6, 7, 0, 1) with correct resolves in order -> the head frees 2 per cycle across the wrap and ends equal to the tail.
REQ-039 Assert reset the cycle after a mispredict -> restore_valid=0 and the buffer is empty with alloc_ready=1.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared types for return-address-stack speculation recovery.
// Used by ras_recovery (checkpoint buffer) and by the RAS itself.
//   RAS_STACK_SIZE / RAS_CKPT_DEPTH : default stack depth and checkpoint count
//   ckpt_tag_t                      : checkpoint tag carried with a branch
//   ckpt_entry_t                    : one checkpoint (ptr, tos, valid, resolved)
package ras_pkg;

  localparam int RAS_STACK_SIZE = 8;
  localparam int RAS_CKPT_DEPTH = 8;
  localparam int RAS_PTR_W      = $clog2(RAS_STACK_SIZE);
  localparam int CKPT_TAG_W     = $clog2(RAS_CKPT_DEPTH);

  typedef logic [CKPT_TAG_W-1:0] ckpt_tag_t;
  typedef logic [RAS_PTR_W-1:0]  ras_ptr_t;

  typedef struct packed {
    ras_ptr_t    ptr;
    logic [31:0] tos;
    logic        valid;
    logic        resolved;
  } ckpt_entry_t;

  // Distance of tag a from tag b going forward around the ring (a - b mod depth).
  function automatic ckpt_tag_t ckpt_dist(input ckpt_tag_t a, input ckpt_tag_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/ras_recovery.sv
// Checkpoint buffer for return-address-stack recovery after branch mispredicts.
// Each predicted branch snapshots the speculative RAS pointer and top entry;
// a mispredict reloads that snapshot into the RAS one cycle later and squashes
// every younger checkpoint. Correctly resolved checkpoints retire in order
// from the head, up to two per cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   alloc_valid[1:0]    per fetch slot, branch needs a checkpoint (slot 0 older)
//   alloc_ptr           {slot1, slot0} speculative RAS pointer
//   alloc_tos           {slot1, slot0} RAS entry at ptr-1
//   alloc_ready         at least two free entries (pre-update occupancy)
//   alloc_tag           {slot1, slot0} tag assigned, combinational
//   resolve_valid/tag/mispredict   one branch resolution per cycle
//   restore_valid/ptr/tos          one-cycle reload command to the RAS
//
// The entry array uses the package entry type, so overriding STACK_SIZE or
// CKPT_DEPTH must be matched by the package defaults.
module ras_recovery
  import ras_pkg::*;
#(
  parameter int STACK_SIZE = RAS_STACK_SIZE,
  parameter int CKPT_DEPTH = RAS_CKPT_DEPTH,
  localparam int PTR_W     = $clog2(STACK_SIZE),
  localparam int TAG_W     = $clog2(CKPT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           alloc_valid,
  input  logic [2*PTR_W-1:0]   alloc_ptr,
  input  logic [63:0]          alloc_tos,
  output logic                 alloc_ready,
  output logic [2*TAG_W-1:0]   alloc_tag,
  input  logic                 resolve_valid,
  input  logic [TAG_W-1:0]     resolve_tag,
  input  logic                 resolve_mispredict,
  output logic                 restore_valid,
  output logic [PTR_W-1:0]     restore_ptr,
  output logic [31:0]          restore_tos
);

  localparam logic [TAG_W:0] READY_MAX = (TAG_W+1)'(CKPT_DEPTH - 2);

  // head/tail carry an extra wrap bit so a full ring differs from an empty one
  logic [TAG_W:0]   head, head_next;
  logic [TAG_W:0]   tail, tail_next;
  logic [TAG_W:0]   occupancy;
  ckpt_entry_t      entries      [CKPT_DEPTH];
  ckpt_entry_t      entries_next [CKPT_DEPTH];

  logic [TAG_W-1:0] tag0, tag1;
  logic [TAG_W-1:0] h0, h1;
  logic             free0, free1;

  ckpt_entry_t      res_entry;
  logic             res_live;
  logic             mispredict_take;
  logic             correct_take;
  logic             alloc_take;
  logic [TAG_W-1:0] mp_off;
  logic [TAG_W:0]   mp_tail;

  assign occupancy   = tail - head;
  assign alloc_ready = (occupancy <= READY_MAX);

  // Slot 1 takes the next tag only when slot 0 actually consumes one.
  assign tag0      = tail[TAG_W-1:0];
  assign tag1      = alloc_valid[0] ? tag0 + TAG_W'(1) : tag0;
  assign alloc_tag = {tag1, tag0};

  // A resolve counts only for a live, not-yet-resolved entry; anything else
  // (squashed, freed, or a second resolve of the same tag) is dropped.
  assign res_entry       = entries[resolve_tag];
  assign res_live        = resolve_valid && res_entry.valid && !res_entry.resolved;
  assign mispredict_take = res_live && resolve_mispredict;
  assign correct_take    = res_live && !resolve_mispredict;
  assign alloc_take      = alloc_ready && !mispredict_take;

  // In-order retirement: the second entry frees only behind the first.
  assign h0    = head[TAG_W-1:0];
  assign h1    = h0 + TAG_W'(1);
  assign free0 = entries[h0].valid && entries[h0].resolved;
  assign free1 = free0 && entries[h1].valid && entries[h1].resolved;

  // Rebuild the full (wrap-bit) pointer of the mispredicted tag from its
  // distance ahead of the head, then cut the tail just past it.
  assign mp_off  = ckpt_dist(resolve_tag, h0);
  assign mp_tail = head + {1'b0, mp_off} + (TAG_W+1)'(1);

  assign head_next = head + (TAG_W+1)'(free0) + (TAG_W+1)'(free1);

  always_comb begin
    tail_next = tail;
    if (mispredict_take) begin
      tail_next = mp_tail;
    end else if (alloc_take) begin
      tail_next = tail + (TAG_W+1)'(alloc_valid[0]) + (TAG_W+1)'(alloc_valid[1]);
    end
  end

  always_comb begin
    for (int i = 0; i < CKPT_DEPTH; i++) begin
      entries_next[i] = entries[i];
    end

    if (free0) begin
      entries_next[h0].valid    = 1'b0;
      entries_next[h0].resolved = 1'b0;
    end
    if (free1) begin
      entries_next[h1].valid    = 1'b0;
      entries_next[h1].resolved = 1'b0;
    end

    if (correct_take) begin
      entries_next[resolve_tag].resolved = 1'b1;
    end

    if (mispredict_take) begin
      entries_next[resolve_tag].resolved = 1'b1;
      // Everything further from the head than T is younger; slots beyond the
      // tail are already invalid, so clearing them too is harmless.
      for (int i = 0; i < CKPT_DEPTH; i++) begin
        if (ckpt_dist(TAG_W'(i), h0) > mp_off) begin
          entries_next[i].valid    = 1'b0;
          entries_next[i].resolved = 1'b0;
        end
      end
    end

    if (alloc_take) begin
      if (alloc_valid[0]) begin
        entries_next[tag0] = '{ptr: alloc_ptr[PTR_W-1:0], tos: alloc_tos[31:0],
                               valid: 1'b1, resolved: 1'b0};
      end
      if (alloc_valid[1]) begin
        entries_next[tag1] = '{ptr: alloc_ptr[2*PTR_W-1:PTR_W], tos: alloc_tos[63:32],
                               valid: 1'b1, resolved: 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < CKPT_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      head <= head_next;
      tail <= tail_next;
      for (int i = 0; i < CKPT_DEPTH; i++) begin
        entries[i] <= entries_next[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      restore_valid <= 1'b0;
      restore_ptr   <= '0;
      restore_tos   <= '0;
    end else begin
      restore_valid <= mispredict_take;
      if (mispredict_take) begin
        restore_ptr <= res_entry.ptr;
        restore_tos <= res_entry.tos;
      end
    end
  end

endmodule
